// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    DT_BYTE = 2'd0,
    DT_HALF = 2'd1,
    DT_WORD = 2'd2
  } mem_dt_e;

  typedef enum logic [1:0] {
    ENOERR = 2'd0,
    EALIGN = 2'd1
  } errno_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DIV_W = 16;

  localparam logic [3:0] UART_OFF_DATA   = 4'h0;
  localparam logic [3:0] UART_OFF_STATUS = 4'h4;
  localparam logic [3:0] UART_OFF_DIV    = 4'h8;
  localparam logic [3:0] UART_OFF_IE     = 4'hC;

  localparam int unsigned STS_BUSY   = 0;
  localparam int unsigned STS_FULL   = 1;
  localparam int unsigned STS_EMPTY  = 2;
  localparam int unsigned STS_OVF    = 3;
  localparam int unsigned STS_CNT_LO = 4;

  // A programmed divisor of zero behaves as one cycle per bit.
  function automatic logic [DIV_W-1:0] div_eff(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO; DEPTH must be a power of two, at least 2.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  // A push while full is accepted only when a pop frees a slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and programmable divisor.
// Optional MMIO_UART_TX_IRQ_EN adds an IE register at 0xC and an irq output.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0]      BASE_ADDR  = 32'h8000_0000,
  parameter logic [15:0]      DIV_RST    = 16'd434,
  parameter int unsigned      FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic        we,
  input  mem_dt_e     dt,
  output logic [31:0] rd,
  output errno_e      err,
  output logic        tx
`ifdef MMIO_UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic             in_win;
  logic             aligned;
  logic             is_word;
  logic [3:0]       off;
  logic             acc_ok;
  logic             data_wr;
  logic             div_wr;
  logic             sts_rd;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;
  logic [CW-1:0]    fifo_count;

  logic [DIV_W-1:0] div_q;
  logic             ovf_q;
  logic             ovf_set;
  logic [3:0]       cnt_sat;
  logic [7:0]       status;
  logic             busy;

  uart_state_e      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] reload_q, reload_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_d;
  logic             bit_end;

  logic             unused_wd;
  assign unused_wd = ^wd[31:16];

  // Address decode
  assign in_win  = (addr[31:4] == BASE_ADDR[31:4]);
  assign off     = addr[3:0];
  assign aligned = (addr[1:0] == 2'b00);
  assign is_word = (dt == DT_WORD);
  assign acc_ok  = in_win && aligned;
  assign data_wr = acc_ok && we && (off == UART_OFF_DATA);
  assign div_wr  = acc_ok && we && is_word && (off == UART_OFF_DIV);
  assign sts_rd  = acc_ok && !we && is_word && (off == UART_OFF_STATUS);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_wr),
    .pop   (fifo_pop),
    .din   (wd[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign ovf_set = data_wr && fifo_full && !fifo_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= DIV_RST;
      ovf_q <= 1'b0;
    end else begin
      if (div_wr) div_q <= wd[15:0];
      // A fresh overflow wins over a clearing read in the same cycle.
      if (ovf_set)     ovf_q <= 1'b1;
      else if (sts_rd) ovf_q <= 1'b0;
    end
  end

`ifdef MMIO_UART_TX_IRQ_EN
  logic ie_q;
  logic ie_wr;

  assign ie_wr = acc_ok && we && is_word && (off == UART_OFF_IE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie_q <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (ie_wr) ie_q <= wd[0];
      irq <= ie_q && fifo_empty && (state_q == IDLE);
    end
  end
`endif

  // Status word
  assign busy    = (state_q != IDLE) || !fifo_empty;
  assign cnt_sat = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);

  always_comb begin
    status                 = '0;
    status[STS_BUSY]       = busy;
    status[STS_FULL]       = fifo_full;
    status[STS_EMPTY]      = fifo_empty;
    status[STS_OVF]        = ovf_q;
    status[STS_CNT_LO+:4]  = cnt_sat;
  end

  // Read data and access status
  always_comb begin
    rd  = '0;
    err = ENOERR;
    if (in_win) begin
      if (!aligned) begin
        err = EALIGN;
      end else begin
        case (off)
          UART_OFF_STATUS: if (is_word) rd = 32'(status); else err = EALIGN;
          UART_OFF_DIV:    if (is_word) rd = 32'(div_q);  else err = EALIGN;
`ifdef MMIO_UART_TX_IRQ_EN
          UART_OFF_IE:     if (is_word) rd = 32'(ie_q);   else err = EALIGN;
`endif
          default: ;
        endcase
      end
    end
  end

  // Serialiser state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= DIV_W'(1);
      idx_q    <= '0;
      shift_q  <= '0;
      tx       <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx       <= tx_d;
    end
  end

  assign bit_end = (cnt_q == '0);

  // Next state; tx is registered from the next-state values so it changes on the transition edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    tx_d     = 1'b1;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d  = START;
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          reload_d = div_eff(div_q);
          cnt_d    = div_eff(div_q) - DIV_W'(1);
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          cnt_d   = reload_q - DIV_W'(1);
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = reload_q - DIV_W'(1);
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            state_d  = START;
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            reload_d = div_eff(div_q);
            cnt_d    = div_eff(div_q) - DIV_W'(1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule
